// File: rtl/pulse_gen_core.sv
// Arm/fire pulse sequencer: delay, then count pulses of width/gap. pulse_o trails state_o by one cycle.
// No backpressure; optional armed-without-fire watchdog under PULSE_GEN_WATCHDOG_EN.
module pulse_gen_core #(
  parameter int CNT_W       = 32,
  parameter int NUM_W       = 16,
  parameter int WDOG_CYCLES = 100000000
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             arm_i,
  input  logic             fire_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] gap_i,
  input  logic [NUM_W-1:0] count_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [1:0]       fault_code_o,
  output logic [2:0]       state_o,
  output logic [NUM_W-1:0] pulses_done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_HIGH  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [NUM_W-1:0] count_q, count_d;
  logic [NUM_W-1:0] pd_q, pd_d;
  logic [1:0]       code_q, code_d;
  logic             fire_q;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             fire_edge;
  logic [NUM_W-1:0] pd_inc;

`ifdef PULSE_GEN_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
  logic [CNT_W-1:0] wdog_q, wdog_d;

  // Held at zero outside ARMED, so it restarts on every entry.
  assign wdog_d = (state_q == S_ARMED) ? wdog_q + CNT_ONE : '0;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`endif

  assign fire_edge = fire_i & ~fire_q;
  assign pd_inc    = pd_q + NUM_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    gap_d   = gap_q;
    count_d = count_q;
    pd_d    = pd_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: if (arm_i) state_d = S_ARMED;
      S_ARMED: begin
        if (abort_i) begin
          state_d = S_FAULT;
          code_d  = 2'd1;
        end else if (!arm_i) begin
          state_d = S_IDLE;
        end else if (fire_edge) begin
          width_d = width_i;
          gap_d   = gap_i;
          count_d = count_i;
          pd_d    = '0;
          if (width_i == '0 || count_i == '0) begin
            state_d = S_FAULT;
            code_d  = 2'd2;
          end else if (delay_i == '0) begin
            state_d = S_HIGH;
            cnt_d   = width_i - CNT_ONE;
          end else begin
            state_d = S_DELAY;
            cnt_d   = delay_i - CNT_ONE;
          end
        end
`ifdef PULSE_GEN_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          state_d = S_FAULT;
          code_d  = 2'd3;
        end
`endif
      end
      S_DELAY, S_HIGH, S_GAP: begin
        if (abort_i || !arm_i) begin
          state_d = S_FAULT;
          code_d  = 2'd1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (state_q == S_HIGH) begin
          pd_d = pd_inc;
          if (pd_inc == count_q) begin
            state_d = S_DONE;
          end else begin
            // A zero gap still costs one low cycle between pulses.
            state_d = S_GAP;
            cnt_d   = (gap_q == '0) ? '0 : gap_q - CNT_ONE;
          end
        end else begin
          state_d = S_HIGH;
          cnt_d   = width_q - CNT_ONE;
        end
      end
      S_DONE, S_FAULT: if (!arm_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != S_FAULT) code_d = '0;
  end

  always_comb begin
    pulse_d = (state_q == S_HIGH);
    busy_d  = (state_d == S_DELAY) || (state_d == S_HIGH) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      gap_q   <= '0;
      count_q <= '0;
      pd_q    <= '0;
      code_q  <= '0;
      fire_q  <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      count_q <= count_d;
      pd_q    <= pd_d;
      code_q  <= code_d;
      fire_q  <= fire_i;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign pulse_o       = pulse_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fault_o       = fault_q;
  assign fault_code_o  = code_q;
  assign state_o       = state_q;
  assign pulses_done_o = pd_q;

endmodule

// File: tb/tb_pulse_gen_core.sv
// Directed bench for pulse_gen_core: per-cycle vector table plus multi-cycle pulse-train sequences.
module tb_pulse_gen_core;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        arm_i, fire_i, abort_i;
  logic [31:0] delay_i, width_i, gap_i;
  logic [15:0] count_i;
  logic        pulse_o, busy_o, done_o, fault_o;
  logic [1:0]  fault_code_o;
  logic [2:0]  state_o;
  logic [15:0] pulses_done_o;

  int checks   = 0;
  int failures = 0;

  pulse_gen_core #(.CNT_W(32), .NUM_W(16), .WDOG_CYCLES(50)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .arm_i(arm_i), .fire_i(fire_i), .abort_i(abort_i),
    .delay_i(delay_i), .width_i(width_i), .gap_i(gap_i), .count_i(count_i),
    .pulse_o(pulse_o), .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o),
    .fault_code_o(fault_code_o), .state_o(state_o), .pulses_done_o(pulses_done_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        arm, fire, abort;
    logic [31:0] dly, wid, gap;
    logic [15:0] cnt;
    logic [2:0]  st;
    logic        pls, bsy, dn, flt;
    logic [1:0]  code;
    logic [15:0] pd;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t v(input logic arm, fire, abort, input int dly, wid, gap, cnt,
                             input int st, pls, bsy, dn, flt, code, pd);
    vec_t r;
    r.arm = arm; r.fire = fire; r.abort = abort;
    r.dly = 32'(dly); r.wid = 32'(wid); r.gap = 32'(gap); r.cnt = 16'(cnt);
    r.st = 3'(st); r.pls = 1'(pls); r.bsy = 1'(bsy); r.dn = 1'(dn); r.flt = 1'(flt);
    r.code = 2'(code); r.pd = 16'(pd);
    return r;
  endfunction

  // Spec pulse train: rises 1+D edges after the fire edge, W high, max(G,1) low, N pulses.
  function automatic logic exp_pulse(input int j, d, w, g, n);
    int t, per;
    t   = j - 1 - d;
    per = w + ((g < 1) ? 1 : g);
    if (t < 0) return 1'b0;
    return ((t / per) < n) && ((t % per) < w);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_in(input logic arm, fire, abort, input int d, w, g, n);
    arm_i = arm; fire_i = fire; abort_i = abort;
    delay_i = 32'(d); width_i = 32'(w); gap_i = 32'(g); count_i = 16'(n);
  endtask

  task automatic arm_up();
    set_in(0, 0, 0, 0, 1, 0, 1); step();
    set_in(1, 0, 0, 0, 1, 0, 1); step();
    chk("arm_up state", 64'(state_o), 64'd1);
  endtask

  task automatic run_train(input string name, input int d, w, g, n);
    logic [63:0] act_v, exp_v;
    act_v = '0; exp_v = '0;
    arm_up();
    set_in(1, 1, 0, d, w, g, n); step();
    // Parameter changes after the fire edge must be ignored.
    set_in(1, 1, 0, 9, 1, 5, 7);
    for (int j = 0; j <= 40; j++) begin
      if (j > 0) step();
      act_v[j] = pulse_o;
      exp_v[j] = exp_pulse(j, d, w, g, n);
    end
    chk({name, " train"}, act_v, exp_v);
    chk({name, " state"}, 64'(state_o), 64'd5);
    chk({name, " done"}, 64'(done_o), 64'd1);
    chk({name, " busy"}, 64'(busy_o), 64'd0);
    chk({name, " pulses"}, 64'(pulses_done_o), 64'(n));
    set_in(0, 0, 0, 0, 1, 0, 1); step();
    chk({name, " idle"}, 64'(state_o), 64'd0);
    chk({name, " done cleared"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    //              arm fi ab dly wid gap cnt   st pl by dn ft cd pd
    tbl[0]  = v(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = v(1, 0, 1, 0, 1, 0, 1,   6, 0, 0, 0, 1, 1, 0);
    tbl[3]  = v(1, 0, 0, 0, 1, 0, 1,   6, 0, 0, 0, 1, 1, 0);
    tbl[4]  = v(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = v(0, 0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = v(1, 0, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = v(1, 1, 0, 0, 0, 0, 3,   6, 0, 0, 0, 1, 2, 0);
    tbl[8]  = v(1, 1, 0, 0, 0, 0, 3,   6, 0, 0, 0, 1, 2, 0);
    tbl[9]  = v(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    tbl[10] = v(1, 1, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[11] = v(1, 1, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[12] = v(1, 0, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[13] = v(0, 1, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    tbl[14] = v(1, 1, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[15] = v(1, 0, 0, 0, 2, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[16] = v(1, 1, 1, 0, 2, 0, 1,   6, 0, 0, 0, 1, 1, 0);
    tbl[17] = v(0, 0, 0, 0, 2, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    tbl[18] = v(1, 0, 0, 0, 2, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    tbl[19] = v(1, 1, 0, 0, 2, 0, 1,   3, 0, 1, 0, 0, 0, 0);
    tbl[20] = v(1, 0, 0, 0, 9, 0, 1,   3, 1, 1, 0, 0, 0, 0);
    tbl[21] = v(1, 0, 0, 0, 9, 0, 1,   5, 1, 0, 1, 0, 0, 1);
    tbl[22] = v(1, 0, 0, 0, 9, 0, 1,   5, 0, 0, 1, 0, 0, 1);
    tbl[23] = v(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 1);
    tbl[24] = v(1, 0, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 1);
    tbl[25] = v(1, 1, 0, 2, 3, 1, 2,   2, 0, 1, 0, 0, 0, 0);
    tbl[26] = v(0, 1, 0, 2, 3, 1, 2,   6, 0, 0, 0, 1, 1, 0);
    tbl[27] = v(0, 0, 0, 2, 3, 1, 2,   0, 0, 0, 0, 0, 0, 0);

    ARESETN = 1'b0;
    set_in(0, 0, 0, 0, 1, 0, 1);
    #3;
    chk("reset state", 64'(state_o), 64'd0);
    chk("reset outputs", 64'({pulse_o, busy_o, done_o, fault_o, fault_code_o}), 64'd0);
    chk("reset pulses", 64'(pulses_done_o), 64'd0);
    #9 ARESETN = 1'b1;

    for (int i = 0; i < 28; i++) begin
      set_in(tbl[i].arm, tbl[i].fire, tbl[i].abort, int'(tbl[i].dly), int'(tbl[i].wid),
             int'(tbl[i].gap), int'(tbl[i].cnt));
      step();
      chk($sformatf("row%0d state", i), 64'(state_o), 64'(tbl[i].st));
      chk($sformatf("row%0d pulse", i), 64'(pulse_o), 64'(tbl[i].pls));
      chk($sformatf("row%0d busy/done/fault", i), 64'({busy_o, done_o, fault_o}),
          64'({tbl[i].bsy, tbl[i].dn, tbl[i].flt}));
      chk($sformatf("row%0d code", i), 64'(fault_code_o), 64'(tbl[i].code));
      chk($sformatf("row%0d pulses_done", i), 64'(pulses_done_o), 64'(tbl[i].pd));
    end

    run_train("d3w5g2n3", 3, 5, 2, 3);
    run_train("d0w1g0n2", 0, 1, 0, 2);
    run_train("d1w2g3n2", 1, 2, 3, 2);

    // Abort in the fourth cycle of a 10-wide pulse.
    arm_up();
    set_in(1, 1, 0, 0, 10, 0, 1); step();
    step(); step(); step();
    chk("abort pre pulse", 64'(pulse_o), 64'd1);
    abort_i = 1'b1; step();
    abort_i = 1'b0; step();
    chk("abort pulse low", 64'(pulse_o), 64'd0);
    chk("abort state", 64'(state_o), 64'd6);
    chk("abort fault", 64'({fault_o, fault_code_o}), 64'({1'b1, 2'd1}));
    chk("abort pulses", 64'(pulses_done_o), 64'd0);
    set_in(0, 0, 0, 0, 1, 0, 1); step();
    chk("abort idle", 64'({fault_o, state_o}), 64'd0);

    // Asynchronous reset mid-pulse.
    arm_up();
    set_in(1, 1, 0, 0, 10, 0, 1); step(); step();
    chk("areset pre pulse", 64'(pulse_o), 64'd1);
    #2 ARESETN = 1'b0;
    #1;
    chk("areset pulse", 64'(pulse_o), 64'd0);
    chk("areset state", 64'({busy_o, state_o}), 64'd0);
    set_in(0, 0, 0, 0, 1, 0, 1);
    #2 ARESETN = 1'b1;
    step();
    chk("post reset idle", 64'(state_o), 64'd0);

    // Armed without fire.
    set_in(1, 0, 0, 0, 1, 0, 1); step();
`ifdef PULSE_GEN_WATCHDOG_EN
    repeat (49) step();
    chk("wdog not yet", 64'(state_o), 64'd1);
    step();
    chk("wdog fault", 64'({state_o, fault_code_o}), 64'({3'd6, 2'd3}));
`else
    repeat (1000) step();
    chk("armed hold", 64'({state_o, fault_o, pulse_o}), 64'({3'd1, 1'b0, 1'b0}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
